// File: rtl/iterative_muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative M-extension unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_t;

  function automatic logic is_div(muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(muldiv_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(muldiv_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(muldiv_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/iterative_muldiv_if.sv
// Issue/result handshake bundle between the pipe and the muldiv unit.
interface iterative_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             InValid;
  logic             InReady;
  logic [2:0]       Op;
  logic [WIDTH-1:0] Rs1;
  logic [WIDTH-1:0] Rs2;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;

  modport master (
    output InValid, Op, Rs1, Rs2, OutReady,
    input  InReady, OutValid, Result
  );

  modport slave (
    input  InValid, Op, Rs1, Rs2, OutReady,
    output InReady, OutValid, Result
  );
endinterface

// File: rtl/iterative_muldiv_div_step.sv
// One restoring-divide iteration: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {2'b00, divisor_i};
    q_o     = ~trial[WIDTH+1];
    rem_o   = q_o ? trial[WIDTH:0] : shifted[WIDTH:0];
  end
endmodule

// File: rtl/iterative_muldiv.sv
// Radix-2 multiply / restoring divide, one bit per cycle.
// Define MULDIV_EARLY_OUT_EN to bypass CALC/FIX for trivial operands.
module iterative_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Flush,
  output logic               Busy,
  iterative_muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  muldiv_state_t      state_q, state_d;
  muldiv_op_t         op_q, op_d, in_op;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               spec_q, spec_d;
  logic [WIDTH-1:0]   spec_val_q, spec_val_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic               neg_a, neg_b, div_zero, ovf, spec_hit;
  logic [WIDTH-1:0]   mag_a, mag_b, spec_val;
  logic [WIDTH:0]     rem_nx, add;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, remd, fix_val;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .divisor_i (opnd_q),
    .bit_i     (acc_q[WIDTH-1]),
    .rem_o     (rem_nx),
    .q_o       (q_bit)
  );

  always_comb begin
    in_op    = muldiv_op_t'(bus.Op);
    neg_a    = is_signed_a(in_op) & bus.Rs1[WIDTH-1];
    neg_b    = is_signed_b(in_op) & bus.Rs2[WIDTH-1];
    mag_a    = neg_a ? -bus.Rs1 : bus.Rs1;
    mag_b    = neg_b ? -bus.Rs2 : bus.Rs2;
    div_zero = is_div(in_op) && (bus.Rs2 == '0);
    ovf      = (in_op == OP_DIV || in_op == OP_REM)
            && (bus.Rs1 == {1'b1, {(WIDTH-1){1'b0}}})
            && (&bus.Rs2);
`ifdef MULDIV_EARLY_OUT_EN
    spec_hit = div_zero | ovf
            | (!is_div(in_op) && (bus.Rs1 == '0 || bus.Rs2 == '0));
`else
    spec_hit = div_zero | ovf;
`endif
    spec_val = '0;
    if (div_zero)
      spec_val = is_rem(in_op) ? bus.Rs1 : '1;
    else if (ovf)
      spec_val = is_rem(in_op) ? '0 : bus.Rs1;
  end

  always_comb begin
    add  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
         + (acc_q[0] ? {1'b0, opnd_q} : '0);
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quot = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remd = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    unique case (op_q)
      OP_MUL:                       fix_val = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_val = quot;
      OP_REM, OP_REMU:              fix_val = remd;
    endcase
    if (spec_q)
      fix_val = spec_val_q;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    unique case (state_q)
      IDLE: begin
        if (bus.InValid && !Flush) begin
          op_d       = in_op;
          sa_d       = neg_a;
          sb_d       = neg_b;
          spec_d     = spec_hit;
          spec_val_d = spec_val;
          // Divide shifts the dividend out of the low accumulator word;
          // multiply shifts the multiplier out of the same place.
          opnd_d     = is_div(in_op) ? mag_b : mag_a;
          acc_d      = {{WIDTH{1'b0}}, is_div(in_op) ? mag_a : mag_b};
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = CALC;
`ifdef MULDIV_EARLY_OUT_EN
          if (spec_hit) begin
            result_d = spec_val;
            state_d  = DONE;
          end
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div(op_q)) begin
          rem_d = rem_nx;
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], q_bit};
        end else begin
          acc_d = {add, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH-1))
          state_d = FIX;
      end
      FIX: begin
        result_d = fix_val;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.OutReady)
          state_d = IDLE;
      end
    endcase
    if (Flush)
      state_d = IDLE;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_MUL;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      spec_q      <= 1'b0;
      spec_val_q  <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      spec_q      <= spec_d;
      spec_val_q  <= spec_val_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.InReady  = in_ready_q;
  assign bus.OutValid = out_valid_q;
  assign bus.Result   = result_q;
  assign Busy         = busy_q;
endmodule

// File: tb/tb_iterative_muldiv.sv
// Directed plus random bench for iterative_muldiv against an arithmetic model.
module tb_iterative_muldiv;
  localparam int W = 32;

  logic clk;
  logic reset;
  logic flush;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  iterative_muldiv_if #(.WIDTH(W)) bus ();

  iterative_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .Flush (flush),
    .Busy  (busy),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    bit sp;
    int l;
    sp = (op[2] && b == 0)
      || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000
          && b == 32'hFFFF_FFFF)
      || (!op[2] && (a == 0 || b == 0));
    l = W + 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (sp) l = 1;
`else
    if (sp) l = W + 2;
`endif
    return l;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    bus.InValid = 1'b1;
    bus.Op      = op;
    bus.Rs1     = a;
    bus.Rs2     = b;
    @(posedge clk);
    #1 bus.InValid = 1'b0;
  endtask

  task automatic finish_op(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit rel);
    int lat;
    bit busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!busy) busy_ok = 1'b0;
    end while (!bus.OutValid && lat < 200);
    chk({tag, "/result"}, bus.Result, exp);
    chk({tag, "/latency"}, lat, exp_lat(op, a, b));
    chk({tag, "/busy"}, busy_ok, 1);
    if (rel) begin
      bus.OutReady = 1'b1;
      @(negedge clk);
      bus.OutReady = 1'b0;
      chk({tag, "/idle"}, {bus.InReady, bus.OutValid, busy}, 3'b100);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    @(negedge clk);
    chk({tag, "/in_ready"}, bus.InReady, 1);
    issue(op, a, b);
    finish_op(tag, op, a, b, exp, 1'b1);
  endtask

  logic [31:0] corners [6];
  logic [31:0] ra, rb, held;
  logic [2:0]  rop;
  bit          seen;

  initial begin
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                32'h7FFF_FFFF, 32'h2};
    reset = 1'b1;
    flush = 1'b0;
    bus.InValid = 1'b0;
    bus.OutReady = 1'b0;
    bus.Op = 3'd0;
    bus.Rs1 = '0;
    bus.Rs2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {bus.InReady, bus.OutValid, busy, bus.Result},
        {3'b100, 32'h0});
    reset = 1'b0;

    run_op("mul_neg",   3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_neg",   3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op("divu",      3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC);
    run_op("div_zero",  3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF);
    run_op("remu_zero", 3'd7, 32'd5,         32'd0,         32'd5);
    run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // Backpressure then back-to-back issue.
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7);
    finish_op("bp", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
    held = bus.Result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {bus.InReady, bus.OutValid, bus.Result},
          {2'b01, held});
    end
    bus.OutReady = 1'b1;
    @(negedge clk);
    bus.OutReady = 1'b0;
    chk("bp_release", {bus.InReady, bus.OutValid, busy}, 3'b100);
    issue(3'd7, 32'd100, 32'd7);
    chk("b2b_accept", {bus.InReady, busy}, 2'b01);
    finish_op("b2b", 3'd7, 32'd100, 32'd7, 32'd2, 1'b1);

    // Flush at CALC counter 10.
    @(negedge clk);
    issue(3'd0, 32'd3, 32'd5);
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_calc", {bus.InReady, bus.OutValid, busy}, 3'b100);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.OutValid) seen = 1'b1;
    end
    chk("flush_no_out", seen, 0);

    // Flush alongside an InValid handshake in IDLE.
    flush = 1'b1;
    issue(3'd0, 32'd3, 32'd5);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_accept", {bus.InReady, busy}, 2'b10);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.OutValid) seen = 1'b1;
    end
    chk("flush_acc_no_out", seen, 0);

    for (int n = 0; n < 24; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)]
                                       : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)]
                                       : 32'($urandom);
      if (n % 3 == 0) rb = rb >> $urandom_range(0, 31);
      run_op($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb,
             ref_model(rop, ra, rb));
    end

    run_op("mul_pre_rst", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    @(negedge clk);
    issue(3'd4, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid", {bus.InReady, bus.OutValid, busy, bus.Result},
        {3'b100, 32'h0});
    run_op("post_rst", 3'd4, 32'd1000, 32'd3, 32'd333);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
